// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid control slave.
// Latency: n/a (signal bundle only).
// Backpressure: slave stalls the master through avm_waitrequest.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/sysid_checker.sv
// Boot-time check: reads sysid words 0 (ID) and 1 (timestamp) and compares them with elaboration constants.
// Latency: 6 cycles from start to done with no stalls; each stall or data-delay cycle adds one.
// Backpressure: holds avm_read/avm_address while waitrequest=1; a per-read timeout retries or gives up.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1367251176,
    parameter int          TIMEOUT_CYCLES     = 1024,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    sysid_checker_if.master    avm,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               id_match,
    output logic               ts_match,
    output logic               timeout_err,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value
);

    localparam int TW     = $clog2(TIMEOUT_CYCLES);
    localparam int RW_RAW = $clog2(MAX_RETRIES + 1);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

    localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic          AUTO_ON   = (AUTO_START != 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ID_REQ  = 3'd1;
    localparam logic [2:0] S_ID_WAIT = 3'd2;
    localparam logic [2:0] S_TS_REQ  = 3'd3;
    localparam logic [2:0] S_TS_WAIT = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          auto_pend_q, auto_pend_d;
    logic          pass_q, pass_d;
    logic          id_match_q, id_match_d;
    logic          ts_match_q, ts_match_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   id_value_q, id_value_d;
    logic [31:0]   ts_value_q, ts_value_d;

    logic in_req, in_wait, cnt_last, rd_req, rd_accept, timeout_hit, go;

    // The request is withdrawn in the last budget cycle so an acceptance can never race the timeout.
    assign in_req      = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
    assign in_wait     = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    assign cnt_last    = (cnt_q == CNT_LAST);
    assign rd_req      = in_req && !cnt_last;
    assign rd_accept   = rd_req && !avm.avm_waitrequest;
    assign timeout_hit = (in_req || in_wait) && cnt_last && !(in_wait && avm.avm_readdatavalid);
    assign go          = start || ((state_q == S_IDLE) && auto_pend_q);

    assign avm.avm_read    = rd_req;
    assign avm.avm_address = (state_q == S_TS_REQ) || (state_q == S_TS_WAIT);
    assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done            = (state_q == S_DONE);
    assign pass            = pass_q;
    assign id_match        = id_match_q;
    assign ts_match        = ts_match_q;
    assign timeout_err     = timeout_err_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

    // Next-state, timeout/retry bookkeeping and result capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        auto_pend_d   = 1'b0;
        pass_d        = pass_q;
        id_match_d    = id_match_q;
        ts_match_d    = ts_match_q;
        timeout_err_d = timeout_err_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d       = S_ID_REQ;
                    cnt_d         = '0;
                    retry_d       = '0;
                    pass_d        = 1'b0;
                    id_match_d    = 1'b0;
                    ts_match_d    = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            S_ID_REQ: begin
                cnt_d = cnt_q + TW'(1);
                if (rd_accept) state_d = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (avm.avm_readdatavalid) begin
                    id_value_d = avm.avm_readdata;
                    state_d    = S_TS_REQ;
                    cnt_d      = '0;
                end
            end
            S_TS_REQ: begin
                cnt_d = cnt_q + TW'(1);
                if (rd_accept) state_d = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (avm.avm_readdatavalid) begin
                    ts_value_d = avm.avm_readdata;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                id_match_d = (id_value_q == EXPECTED_ID);
                ts_match_d = (ts_value_q == EXPECTED_TIMESTAMP);
                pass_d     = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP)
                             && !timeout_err_q;
                state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // A timeout restarts the whole sequence from the ID read, or gives up once retries run out.
        if (timeout_hit) begin
            if (retry_q < RETRY_MAX) begin
                retry_d    = retry_q + RW'(1);
                state_d    = S_ID_REQ;
                cnt_d      = '0;
                id_value_d = '0;
                ts_value_d = '0;
            end else begin
                state_d       = S_DONE;
                timeout_err_d = 1'b1;
                pass_d        = 1'b0;
                id_match_d    = 1'b0;
                ts_match_d    = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; the auto-start flag survives only into the first post-reset cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            retry_q       <= '0;
            auto_pend_q   <= AUTO_ON;
            pass_q        <= 1'b0;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            auto_pend_q   <= auto_pend_d;
            pass_q        <= pass_d;
            id_match_q    <= id_match_d;
            ts_match_q    <= ts_match_d;
            timeout_err_q <= timeout_err_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: scripted and random slave behaviour checked against a cycle-budget reference model.
// Latency: n/a.
// Backpressure: the slave model stalls and delays responses per a per-request plan.
module tb_sysid_checker;

    localparam int          T   = 16;
    localparam int          MR  = 3;
    localparam logic [31:0] EID = 32'd0;
    localparam logic [31:0] ETS = 32'd1367251176;

    typedef struct {
        int          w;    // waitrequest cycles before acceptance
        int          l;    // readdatavalid delay after acceptance, 0 = never respond
        logic [31:0] dat;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, id_match, ts_match, timeout_err;
    logic [31:0] id_value, ts_value;

    sysid_checker_if avm_if ();

    sysid_checker #(
        .EXPECTED_ID        (EID),
        .EXPECTED_TIMESTAMP (ETS),
        .TIMEOUT_CYCLES     (T),
        .MAX_RETRIES        (MR),
        .AUTO_START         (1)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .start       (start),
        .avm         (avm_if),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_match    (id_match),
        .ts_match    (ts_match),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic rd_t mk(input int w, input int l, input logic [31:0] dat);
        rd_t e;
        e.w = w;
        e.l = l;
        e.dat = dat;
        return e;
    endfunction

    // ---------------- slave model ----------------
    rd_t  plan[$];
    int   got_addr[$];
    int   addr_err = 0;

    initial begin
        rd_t         e;
        bit          in_req, pend;
        int          stall, pk, plat;
        logic [31:0] pdat;
        logic        caddr;
        in_req = 0; pend = 0; stall = 0; pk = 0; plat = 0; pdat = '0; caddr = 1'b0;
        e = mk(0, 0, '0);
        avm_if.avm_waitrequest   = 1'b0;
        avm_if.avm_readdatavalid = 1'b0;
        avm_if.avm_readdata      = '0;
        forever begin
            @(negedge clk);
            #1;
            avm_if.avm_readdatavalid = 1'b0;
            if (rst) begin
                pend = 0;
                in_req = 0;
                avm_if.avm_waitrequest = 1'b0;
            end else begin
                if (pend) begin
                    pk++;
                    if (pk == plat) begin
                        avm_if.avm_readdatavalid = 1'b1;
                        avm_if.avm_readdata      = pdat;
                        pend = 0;
                    end
                end
                if (avm_if.avm_read) begin
                    if (!in_req) begin
                        in_req = 1;
                        stall  = 0;
                        if (plan.size() > 0) e = plan.pop_front();
                        else e = mk(0, 0, '0);
                        caddr = avm_if.avm_address;
                        got_addr.push_back(int'(caddr));
                    end else if (avm_if.avm_address !== caddr) begin
                        addr_err++;
                    end
                    if (stall < e.w) begin
                        avm_if.avm_waitrequest = 1'b1;
                        stall++;
                    end else begin
                        avm_if.avm_waitrequest = 1'b0;
                        in_req = 0;
                        if (e.l != 0) begin
                            pend = 1; pk = 0; plat = e.l; pdat = e.dat;
                        end
                    end
                end else begin
                    in_req = 0;
                    avm_if.avm_waitrequest = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // A read succeeds when its stall plus response delay fits inside the T-cycle budget
    // (last budget slot is count T-1); it then costs w+1+l cycles, a timed-out read costs T.
    rd_t         stim[$];
    int          m_off;
    bit          m_pass, m_idm, m_tsm, m_terr;
    logic [31:0] m_idv = '0, m_tsv = '0;
    int          m_addr[$];

    task automatic model_run();
        int idx = 0;
        int retries = 0;
        bit ok;
        m_addr.delete();
        m_off = 1;
        forever begin
            ok = 1;
            for (int r = 0; r < 2; r++) begin
                rd_t e;
                e = stim[idx];
                idx++;
                m_addr.push_back(r);
                if (e.l != 0 && e.w + e.l <= T - 1) begin
                    m_off += e.w + 1 + e.l;
                    if (r == 0) m_idv = e.dat; else m_tsv = e.dat;
                end else begin
                    m_off += T;
                    ok = 0;
                    break;
                end
            end
            if (ok) begin
                m_off += 1;
                m_idm  = (m_idv == EID);
                m_tsm  = (m_tsv == ETS);
                m_pass = m_idm && m_tsm;
                m_terr = 0;
                break;
            end else if (retries < MR) begin
                retries++;
                m_idv = '0;
                m_tsv = '0;
            end else begin
                m_terr = 1; m_pass = 0; m_idm = 0; m_tsm = 0;
                break;
            end
        end
    endtask

    // ---------------- run/check helpers ----------------
    bit rd_hist [0:511];
    bit ad_hist [0:511];

    task automatic arm();
        model_run();
        got_addr.delete();
        addr_err = 0;
        plan = stim;
    endtask

    task automatic run_check(input string tag, input int t0, input bit poke);
        int seen = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            rd_hist[k] = avm_if.avm_read;
            ad_hist[k] = avm_if.avm_address;
            if (done) begin
                seen = cyc - t0;
                break;
            end
            if (poke && busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        chk_eq({tag, ".latency"}, seen, m_off);
        chk_eq({tag, ".pass"}, pass, m_pass);
        chk_eq({tag, ".id_match"}, id_match, m_idm);
        chk_eq({tag, ".ts_match"}, ts_match, m_tsm);
        chk_eq({tag, ".timeout_err"}, timeout_err, m_terr);
        chk_eq({tag, ".busy"}, busy, 0);
        if (!m_terr) begin
            chk_eq({tag, ".id_value"}, id_value, m_idv);
            chk_eq({tag, ".ts_value"}, ts_value, m_tsv);
        end
        chk_eq({tag, ".nreq"}, got_addr.size(), m_addr.size());
        for (int i = 0; i < got_addr.size() && i < m_addr.size(); i++)
            chk_eq({tag, ".addr"}, got_addr[i], m_addr[i]);
        chk_eq({tag, ".addr_stable"}, addr_err, 0);
    endtask

    task automatic start_check(input string tag, input bit poke);
        int t0;
        arm();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        run_check(tag, t0, poke);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, ".busy"}, busy, 0);
        chk_eq({tag, ".done"}, done, 0);
        chk_eq({tag, ".pass"}, pass, 0);
        chk_eq({tag, ".id_match"}, id_match, 0);
        chk_eq({tag, ".ts_match"}, ts_match, 0);
        chk_eq({tag, ".timeout_err"}, timeout_err, 0);
        chk_eq({tag, ".avm_read"}, avm_if.avm_read, 0);
        chk_eq({tag, ".avm_address"}, avm_if.avm_address, 0);
        chk_eq({tag, ".id_value"}, id_value, 0);
        chk_eq({tag, ".ts_value"}, ts_value, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Nominal match via auto-start: the cycle reset drops is the start cycle.
        stim.delete();
        stim.push_back(mk(0, 1, EID));
        stim.push_back(mk(0, 1, ETS));
        arm();
        rst = 1'b0;
        t0 = cyc;
        run_check("nominal", t0, 0);
        chk_eq("nominal.latency6", m_off, 6);

        // Timestamp off by one.
        stim.delete();
        stim.push_back(mk(0, 1, EID));
        stim.push_back(mk(0, 1, ETS + 32'd1));
        start_check("ts_mismatch", 0);

        // Five stall cycles and 3-cycle response delay on both reads.
        stim.delete();
        stim.push_back(mk(5, 3, EID));
        stim.push_back(mk(5, 3, ETS));
        start_check("backpressure", 0);
        chk_eq("backpressure.latency20", m_off, 20);

        // First ID read never answered, retry succeeds.
        stim.delete();
        stim.push_back(mk(0, 0, 32'hDEAD_BEEF));
        stim.push_back(mk(0, 1, EID));
        stim.push_back(mk(0, 1, ETS));
        start_check("recovery", 0);
        chk_eq("recovery.read_at16", rd_hist[16], 0);
        chk_eq("recovery.read_at17", rd_hist[17], 1);
        chk_eq("recovery.addr_at17", ad_hist[17], 0);

        // Silent slave: four attempts then give up; the last answer arrives late and is ignored.
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(mk(0, 0, EID));
        stim.push_back(mk(0, 20, EID));
        start_check("exhausted", 0);
        repeat (25) @(negedge clk);
        chk_eq("exhausted.hold_done", done, 1);
        chk_eq("exhausted.hold_terr", timeout_err, 1);
        chk_eq("exhausted.hold_pass", pass, 0);

        // Random slave timing and data, with stray start pulses while busy.
        for (int n = 0; n < 20; n++) begin
            stim.delete();
            for (int i = 0; i < 2 * (MR + 1); i++) begin
                int w, l;
                logic [31:0] d;
                w = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 6));
                l = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 6));
                if ($urandom_range(0, 1) == 1) d = (i % 2 == 0) ? EID : ETS;
                else d = $urandom();
                stim.push_back(mk(w, l, d));
            end
            start_check("random", 1);
        end

        // Reset in TS_WAIT, with a stray start while busy beforehand.
        stim.delete();
        stim.push_back(mk(0, 1, EID));
        stim.push_back(mk(0, 4, ETS));
        arm();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = (k == 2) ? 1'b1 : 1'b0;
            if (k == 5) begin
                start = 1'b0;
                rst = 1'b1;
            end
        end
        @(negedge clk);
        chk_all_zero("mid_reset");
        m_idv = '0;
        m_tsv = '0;
        stim.delete();
        stim.push_back(mk(0, 1, EID));
        stim.push_back(mk(0, 1, ETS));
        arm();
        rst = 1'b0;
        t0 = cyc;
        run_check("post_reset", t0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time system-ID verifier that sits directly downstream of the Qsys sysid peripheral, on the Avalon-MM master side of its control slave. It issues two reads: address 0 (system ID) and address 1 (build timestamp). It compares both words against expected values supplied at elaboration and reports pass/fail, so software or a status LED can reject a mismatched FPGA image. It retries reads on timeout and never hangs the interconnect.

## Interface
- EXPECTED_ID, 32'd0, expected word at sysid address 0
- EXPECTED_TIMESTAMP, 32'd1367251176, expected word at sysid address 1
- TIMEOUT_CYCLES, 1024, cycles allowed per read (request through readdatavalid); must be ≥ 2
- MAX_RETRIES, 3, full-sequence retries after a timeout; 0 means no retry
- AUTO_START, 1, 1 = start a check in the first cycle after reset deasserts
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a check when sampled in IDLE or DONE
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; a request is accepted when avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  read data, valid with avm_readdatavalid
- avm_readdatavalid  in  1  read data strobe
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level; high in DONE; cleared when a new check starts
- pass  out  1  id_match & ts_match & ~timeout_err; valid while done=1
- id_match  out  1  captured ID equals EXPECTED_ID
- ts_match  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- timeout_err  out  1  retries exhausted without completing both reads
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation
- The state machine has these states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE.
- **IDLE**: waits for start, or for the first post-reset cycle when AUTO_START=1, then goes to ID_REQ. On that transition done, pass, id_match, ts_match and timeout_err clear, and the retry counter clears.
- **ID_REQ**: avm_read=1 and avm_address=0.
  - Read accepted → ID_WAIT. avm_read drops in the next cycle.
  - Held while avm_waitrequest=1; address stays stable.
- **ID_WAIT**: avm_read=0.
  - avm_readdatavalid=1 → capture avm_readdata into id_value, then go to TS_REQ.
- **TS_REQ / TS_WAIT**: same behaviour with avm_address=1; the captured word goes into ts_value, then → CHECK.
- **CHECK**: registers id_match, ts_match and pass, then → DONE.
- **DONE**: done=1 and all results hold. A start pulse → ID_REQ, with the same clearing as in IDLE.
- **Timeout counter**:
  - Clears when the FSM enters ID_REQ or TS_REQ.
  - Increments every cycle in the REQ and WAIT states.
  - Reaching TIMEOUT_CYCLES−1 without data → timeout. avm_read deasserts immediately.
  - On timeout, if retries < MAX_RETRIES: retries+1, restart at ID_REQ and clear both captured words.
  - Otherwise: go to DONE with timeout_err=1, pass=0, id_match=0, ts_match=0.
- **Widths**: timeout counter is clog2(TIMEOUT_CYCLES) bits; retry counter is clog2(MAX_RETRIES+1) bits, minimum 1. The comparison is a full 32-bit equality.
- **Ignored inputs**:
  - avm_readdatavalid outside ID_WAIT/TS_WAIT, e.g. a late response after a timeout.
  - start while busy=1.

## Timing
- **Reset values**: all outputs are 0 (avm_read, avm_address, busy, done, pass, id_match, ts_match, timeout_err, id_value, ts_value).
- **Reset mid-operation**: in the next cycle the FSM is in IDLE, avm_read=0 and all outputs are 0. The read in flight is abandoned.
- **Best-case latency** (waitrequest=0, readdatavalid 1 cycle after acceptance, start sampled at cycle 0):
  - ID_REQ at cycle 1, ID_WAIT at 2, TS_REQ at 3, TS_WAIT at 4, CHECK at 5.
  - done=1 from cycle 6; 6 cycles total.
- Each waitrequest cycle or readdatavalid delay cycle adds one cycle.
- avm_read is never high in the same cycle as a WAIT state or after a timeout. At most one read is outstanding.
- A timeout followed by a retry reasserts avm_read 1 cycle later, in ID_REQ.

## Test plan
- **Nominal match**: slave returns 0 / 1367251176 with zero wait and 1-cycle valid latency → done at cycle 6, pass=1, id_match=1, ts_match=1, id_value=0, ts_value=1367251176.
- **Timestamp mismatch**: slave returns 0 / 1367251177 → done=1, pass=0, id_match=1, ts_match=0, ts_value=1367251177.
- **Backpressure**: waitrequest held 5 cycles on each read, readdatavalid 3 cycles after acceptance → avm_address stable while stalled, pass=1, done at cycle 6+10+4=20.
- **Timeout with recovery**: TIMEOUT_CYCLES=16, no valid on the first ID read, normal response afterwards → avm_read drops at cycle 16 of the read, reasserts next cycle with address 0, final pass=1, timeout_err=0.
- **Retries exhausted**: TIMEOUT_CYCLES=16, MAX_RETRIES=3, slave silent → 4 attempts, then done=1, timeout_err=1, pass=0. A late readdatavalid is ignored.
- **Reset mid-read and restart**: assert reset while in TS_WAIT → next cycle all outputs are 0. With AUTO_START=1, ID_REQ follows. A start pulse while busy does not disturb the sequence.
